// File: rtl/pulpemu_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pulpemu_uart_pkg
// Purpose  : Shared constants and receiver FSM state encoding for the
//            emulation-side UART receiver.
// Contents : UART_DATA_BITS - bits per character
//            UART_MIN_DIV   - smallest usable bit-period divider
//            uart_rx_state_e - receiver FSM states (explicit 3-bit encoding)
// Revision : 1.0 - initial release
// ============================================================================
package pulpemu_uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_MIN_DIV   = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_rx_state_e;

endpackage
`default_nettype wire

// File: rtl/pulpemu_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : pulpemu_uart_rx_fifo
// Purpose  : Small synchronous FIFO with a registered head word and a
//            registered valid flag, used to buffer received characters.
// Ports    : clk_i, rstn_i      - clock, async active-low reset
//            push_i, wdata_i    - write request and data
//            pop_i              - read request (ignored when empty)
//            head_o, valid_o    - registered head word / non-empty flag
//            full_o, empty_o    - occupancy status
// Revision : 1.0 - initial release
// ============================================================================
module pulpemu_uart_rx_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int WIDTH      = 8
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             valid_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] C_DEPTH = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] C_ONE   = (AW+1)'(1);

  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_head;
  logic             r_valid;

  logic             w_do_push;
  logic             w_do_pop;
  logic             w_head_from_wr;
  logic [AW-1:0]    w_rptr_nxt;
  logic [AW:0]      w_count_nxt;
  logic [WIDTH-1:0] w_head_nxt;

  assign full_o  = (r_count == C_DEPTH);
  assign empty_o = (r_count == '0);
  assign head_o  = r_head;
  assign valid_o = r_valid;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_do_pop  = pop_i & ~empty_o;
  assign w_do_push = push_i & (~full_o | w_do_pop);

  assign w_rptr_nxt = w_do_pop ? r_rptr + AW'(1) : r_rptr;

  // The incoming word becomes the head when nothing older survives this cycle.
  assign w_head_from_wr = empty_o | ((r_count == C_ONE) & w_do_pop);

  always_comb begin
    w_count_nxt = r_count;
    if (w_do_push && !w_do_pop) begin
      w_count_nxt = r_count + C_ONE;
    end else if (!w_do_push && w_do_pop) begin
      w_count_nxt = r_count - C_ONE;
    end
  end

  always_comb begin
    w_head_nxt = r_head;
    if (w_do_push && w_head_from_wr) begin
      w_head_nxt = wdata_i;
    end else if (w_do_pop && (r_count > C_ONE)) begin
      w_head_nxt = r_mem[w_rptr_nxt];
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_head  <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      r_rptr  <= w_rptr_nxt;
      r_count <= w_count_nxt;
      r_head  <= w_head_nxt;
      r_valid <= (w_count_nxt != '0);
    end
  end

endmodule
`default_nettype wire

// File: rtl/pulpemu_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : pulpemu_uart_rx
// Purpose  : UART receiver sampling PULP's serial TX line, deframing 8-bit
//            characters (optional parity) into a small elastic FIFO exposed
//            as a valid/ready stream.
// Ports    : clk_i, rstn_i                     - clock, async active-low reset
//            rx_i                              - asynchronous serial line
//            cfg_div_i                         - bit period minus 1 (min 3)
//            cfg_parity_en_i, cfg_parity_odd_i - parity configuration
//            rx_data_o, rx_valid_o, rx_ready_i - received byte stream
//            frame_err_o, parity_err_o, overrun_o - sticky error flags
//            clr_err_i                         - clear sticky flags
//            busy_o                            - a frame is in progress
// Revision : 1.0 - initial release
// ============================================================================
module pulpemu_uart_rx
  import pulpemu_uart_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        rx_i,
  input  logic [15:0] cfg_div_i,
  input  logic        cfg_parity_en_i,
  input  logic        cfg_parity_odd_i,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic        frame_err_o,
  output logic        parity_err_o,
  output logic        overrun_o,
  input  logic        clr_err_i,
  output logic        busy_o
);

  localparam logic [15:0] C_MIN_DIV  = 16'(UART_MIN_DIV);
  localparam logic [2:0]  C_LAST_BIT = 3'(UART_DATA_BITS - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  uart_rx_state_e         r_state;
  logic [15:0]            r_cnt;
  logic [15:0]            r_div;
  logic                   r_par_en;
  logic                   r_par_odd;
  logic [2:0]             r_bit_idx;
  logic [7:0]             r_shreg;
  logic                   r_par_acc;
  logic                   r_bad;
  logic                   r_frame_err;
  logic                   r_parity_err;
  logic                   r_overrun;

  logic                   w_rx_s;
  logic [15:0]            w_div_eff;
  logic [15:0]            w_half_m1;
  logic                   w_tick;
  logic                   w_par_exp;
  logic                   w_set_parity;
  logic                   w_set_frame;
  logic                   w_push;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;
  logic                   w_set_overrun;

  // Synchronizer: resets to idle-high so reset never looks like a start bit.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], rx_i};
    end
  end

  assign w_rx_s = r_sync[SYNC_STAGES-1];

  assign w_div_eff = (cfg_div_i < C_MIN_DIV) ? C_MIN_DIV : cfg_div_i;

  // (d+1)>>1 rewritten as (d>>1)+d[0] to stay within 16 bits.
  assign w_half_m1 = (w_div_eff >> 1) + {15'd0, w_div_eff[0]} - 16'd1;

  assign w_tick = (r_cnt == 16'd0);

  // r_par_acc holds the XOR of the data bits; odd parity expects its inverse.
  assign w_par_exp    = r_par_odd ? ~r_par_acc : r_par_acc;
  assign w_set_parity = (r_state == ST_PARITY) & w_tick & (w_rx_s != w_par_exp);
  assign w_set_frame  = (r_state == ST_STOP) & w_tick & ~w_rx_s;
  assign w_push       = (r_state == ST_STOP) & w_tick & w_rx_s & ~r_bad;

  assign w_set_overrun = w_push & w_fifo_full & ~(~w_fifo_empty & rx_ready_i);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_div     <= C_MIN_DIV;
      r_par_en  <= 1'b0;
      r_par_odd <= 1'b0;
      r_bit_idx <= '0;
      r_shreg   <= '0;
      r_par_acc <= 1'b0;
      r_bad     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_rx_s) begin
            r_div     <= w_div_eff;
            r_par_en  <= cfg_parity_en_i;
            r_par_odd <= cfg_parity_odd_i;
            r_cnt     <= w_half_m1;
            r_bad     <= 1'b0;
            r_state   <= ST_START;
          end
        end
        ST_START: begin
          if (w_tick) begin
            if (w_rx_s) begin
              // Line back high at mid start bit: a glitch, not a frame.
              r_state <= ST_IDLE;
            end else begin
              r_cnt     <= r_div;
              r_bit_idx <= '0;
              r_par_acc <= 1'b0;
              r_state   <= ST_DATA;
            end
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            r_shreg   <= {w_rx_s, r_shreg[7:1]};
            r_par_acc <= r_par_acc ^ w_rx_s;
            r_cnt     <= r_div;
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == C_LAST_BIT) begin
              r_state <= r_par_en ? ST_PARITY : ST_STOP;
            end
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        ST_PARITY: begin
          if (w_tick) begin
            if (w_set_parity) begin
              r_bad <= 1'b1;
            end
            r_cnt   <= r_div;
            r_state <= ST_STOP;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        ST_STOP: begin
          if (w_tick) begin
            // Returning to IDLE mid stop bit lets back-to-back frames resync.
            r_state <= w_rx_s ? ST_IDLE : ST_BREAK;
          end else begin
            r_cnt <= r_cnt - 16'd1;
          end
        end
        ST_BREAK: begin
          if (w_rx_s) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky flags: a new event wins over a simultaneous clear.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_frame_err  <= w_set_frame   | (r_frame_err  & ~clr_err_i);
      r_parity_err <= w_set_parity  | (r_parity_err & ~clr_err_i);
      r_overrun    <= w_set_overrun | (r_overrun    & ~clr_err_i);
    end
  end

  pulpemu_uart_rx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (UART_DATA_BITS)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (w_push),
    .wdata_i (r_shreg),
    .pop_i   (rx_ready_i),
    .head_o  (rx_data_o),
    .valid_o (rx_valid_o),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty)
  );

  assign frame_err_o  = r_frame_err;
  assign parity_err_o = r_parity_err;
  assign overrun_o    = r_overrun;
  assign busy_o       = (r_state != ST_IDLE);

endmodule
`default_nettype wire
